// File: rtl/fifo_uart_tx_pkg.sv
// Shared UART definitions: state encodings, line idle level and frame length.
// The transmitter uses them today; a future receiver is meant to reuse them.
package fifo_uart_tx_pkg;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_START_ENC = 2'd1;
  localparam logic [1:0] ST_DATA_ENC  = 2'd2;
  localparam logic [1:0] ST_STOP_ENC  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_START = ST_START_ENC,
    ST_DATA  = ST_DATA_ENC,
    ST_STOP  = ST_STOP_ENC
  } uart_state_t;

  localparam logic IDLE_LEVEL = 1'b1;

  // Cycles per frame: start bit + width data bits + stop bit, each period cycles long.
  function automatic int unsigned frame_len(input int unsigned width, input int unsigned period);
    return (width + 2) * period;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read side of a fifo: head data and empty flag from the fifo, pop back to it.
// master = the fifo, slave = the consumer draining it.
interface fifo_uart_tx_if #(
  parameter int WIDTH = 8
);
  logic             empty;
  logic [WIDTH-1:0] data;
  logic             pop;

  modport master (output empty, output data, input pop);
  modport slave  (input empty, input data, output pop);
endinterface

// File: rtl/fifo_uart_tx.sv
// Fifo drain stage: pops one entry per frame and sends it as start + data (LSB first) + stop.
// Frames run back-to-back because the pop for the next frame happens on the last stop cycle.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PERIOD_W = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cg,
  fifo_uart_tx_if.slave       fifo,
  input  logic [PERIOD_W-1:0] i_bitPeriod,
  output logic                o_tx,
  output logic                o_busy,
  output logic                o_frameDone
);

  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  uart_state_t         state, state_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0]    shift_q, shift_d;
  logic                tx_d;
  logic                last_cycle;
  logic                pop;

  // period_q is never 0, so the terminal count is always reachable.
  assign last_cycle  = (cnt_q == period_q - PERIOD_W'(1));
  assign pop         = i_rst & i_cg & ~fifo.empty &
                       ((state == ST_IDLE) | ((state == ST_STOP) & last_cycle));
  assign fifo.pop    = pop;
  assign o_busy      = (state != ST_IDLE);
  assign o_frameDone = i_cg & (state == ST_STOP) & last_cycle;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state    <= ST_IDLE;
      period_q <= PERIOD_W'(1);
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      o_tx     <= IDLE_LEVEL;
    end else begin
      state    <= state_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      o_tx     <= tx_d;
    end
  end

  always_comb begin
    state_d  = state;
    period_d = period_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = o_tx;
    if (i_cg) begin
      cnt_d = last_cycle ? '0 : cnt_q + PERIOD_W'(1);
      unique case (state)
        ST_IDLE: begin
          cnt_d = '0;
          tx_d  = IDLE_LEVEL;
        end
        ST_START: begin
          if (last_cycle) begin
            state_d = ST_DATA;
            tx_d    = shift_q[0];
          end
        end
        ST_DATA: begin
          if (last_cycle) begin
            if (bit_q == BIT_W'(WIDTH - 1)) begin
              state_d = ST_STOP;
              tx_d    = IDLE_LEVEL;
            end else begin
              shift_d = shift_q >> 1;
              bit_d   = bit_q + BIT_W'(1);
              tx_d    = shift_d[0];
            end
          end
        end
        ST_STOP: begin
          if (last_cycle) begin
            state_d = ST_IDLE;
            tx_d    = IDLE_LEVEL;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      // A pop overrides the STOP->IDLE exit so the next start bit follows immediately.
      if (pop) begin
        state_d  = ST_START;
        shift_d  = fifo.data;
        cnt_d    = '0;
        bit_d    = '0;
        period_d = (i_bitPeriod == '0) ? PERIOD_W'(1) : i_bitPeriod;
        tx_d     = ~IDLE_LEVEL;
      end
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: a queue stands in for the upstream fifo and
// each scenario task compares a captured trace against hand-derived frame timing.
module tb_fifo_uart_tx;

  logic        clk;
  logic        rst_n;
  logic        cg;
  logic [15:0] bit_period;
  logic        tx;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  logic [7:0] fq[$];
  logic       tr_tx  [0:63];
  logic       tr_pop [0:63];
  logic       tr_busy[0:63];
  logic       tr_done[0:63];

  fifo_uart_tx_if #(.WIDTH(8)) ifc ();

  fifo_uart_tx #(.WIDTH(8), .PERIOD_W(16)) dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .i_cg        (cg),
    .fifo        (ifc.slave),
    .i_bitPeriod (bit_period),
    .o_tx        (tx),
    .o_busy      (busy),
    .o_frameDone (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line level at offset i from the pop cycle of an 8-bit frame with period p.
  function automatic logic exp_tx(input int i, input logic [7:0] d, input int p);
    logic [7:0] s;
    if (i <= 0 || i > 9 * p) return 1'b1;
    if (i <= p) return 1'b0;
    s = d >> ((i - 1) / p - 1);
    return s[0];
  endfunction

  task automatic refresh();
    ifc.empty = (fq.size() == 0);
    ifc.data  = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] v);
    fq.push_back(v);
    refresh();
  endtask

  // Called once inputs have settled; advances to the next negedge and retires a pop.
  task automatic step();
    logic pop_now;
    pop_now = ifc.pop;
    @(negedge clk);
    if (pop_now && fq.size() != 0) void'(fq.pop_front());
    refresh();
  endtask

  task automatic capture(input int n, input int cg_lo, input int cg_hi,
                         input int chg_idx, input logic [15:0] chg_val);
    for (int i = 0; i < n; i++) begin
      cg = !(i >= cg_lo && i <= cg_hi);
      if (i == chg_idx) bit_period = chg_val;
      #1;
      tr_tx[i]   = tx;
      tr_pop[i]  = ifc.pop;
      tr_busy[i] = busy;
      tr_done[i] = done;
      step();
    end
    cg = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    tests++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx got %b want 1", tx); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (ifc.pop !== 1'b0) begin fails++; $display("FAIL reset_pop got %b want 0", ifc.pop); end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_idle_empty();
    int bad;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (ifc.pop !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
      step();
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL idle_empty bad_cycles got %0d want 0", bad); end
  endtask

  task automatic test_single_frame();
    bit_period = 16'd4;
    push(8'hA5);
    capture(43, -1, -1, -1, 16'd0);
    for (int i = 0; i < 43; i++) begin
      tests++; if (tr_tx[i] !== exp_tx(i, 8'hA5, 4)) begin fails++; $display("FAIL single_tx[%0d] got %b want %b", i, tr_tx[i], exp_tx(i, 8'hA5, 4)); end
      tests++; if (tr_pop[i] !== (i == 0)) begin fails++; $display("FAIL single_pop[%0d] got %b want %b", i, tr_pop[i], i == 0); end
      tests++; if (tr_done[i] !== (i == 40)) begin fails++; $display("FAIL single_done[%0d] got %b want %b", i, tr_done[i], i == 40); end
      tests++; if (tr_busy[i] !== (i >= 1 && i <= 40)) begin fails++; $display("FAIL single_busy[%0d] got %b want %b", i, tr_busy[i], i >= 1 && i <= 40); end
    end
  endtask

  task automatic test_back_to_back();
    logic e;
    bit_period = 16'd2;
    push(8'h00);
    push(8'hFF);
    capture(43, -1, -1, -1, 16'd0);
    for (int i = 0; i < 43; i++) begin
      e = (i <= 20) ? exp_tx(i, 8'h00, 2) : exp_tx(i - 20, 8'hFF, 2);
      tests++; if (tr_tx[i] !== e) begin fails++; $display("FAIL b2b_tx[%0d] got %b want %b", i, tr_tx[i], e); end
      tests++; if (tr_pop[i] !== (i == 0 || i == 20)) begin fails++; $display("FAIL b2b_pop[%0d] got %b want %b", i, tr_pop[i], i == 0 || i == 20); end
      tests++; if (tr_done[i] !== (i == 20 || i == 40)) begin fails++; $display("FAIL b2b_done[%0d] got %b want %b", i, tr_done[i], i == 20 || i == 40); end
      tests++; if (tr_busy[i] !== (i >= 1 && i <= 40)) begin fails++; $display("FAIL b2b_busy[%0d] got %b want %b", i, tr_busy[i], i >= 1 && i <= 40); end
    end
  endtask

  task automatic test_zero_period();
    bit_period = 16'd0;
    push(8'h3C);
    capture(12, -1, -1, -1, 16'd0);
    for (int i = 0; i < 12; i++) begin
      tests++; if (tr_tx[i] !== exp_tx(i, 8'h3C, 1)) begin fails++; $display("FAIL zero_tx[%0d] got %b want %b", i, tr_tx[i], exp_tx(i, 8'h3C, 1)); end
      tests++; if (tr_done[i] !== (i == 10)) begin fails++; $display("FAIL zero_done[%0d] got %b want %b", i, tr_done[i], i == 10); end
      tests++; if (tr_busy[i] !== (i >= 1 && i <= 10)) begin fails++; $display("FAIL zero_busy[%0d] got %b want %b", i, tr_busy[i], i >= 1 && i <= 10); end
    end
  endtask

  task automatic test_clock_gate();
    logic e;
    bit_period = 16'd4;
    cg = 1'b0;
    push(8'hC4);
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (ifc.pop !== 1'b0) begin fails++; $display("FAIL cg_idle_pop[%0d] got %b want 0", i, ifc.pop); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL cg_idle_busy[%0d] got %b want 0", i, busy); end
      step();
    end
    // Data bit 2 spans offsets 13..16; gating 14..16 stretches it to 13..19.
    capture(46, 14, 16, -1, 16'd0);
    for (int i = 0; i < 46; i++) begin
      if (i <= 12) e = exp_tx(i, 8'hC4, 4);
      else if (i <= 19) e = 1'b1;
      else e = exp_tx(i - 3, 8'hC4, 4);
      tests++; if (tr_tx[i] !== e) begin fails++; $display("FAIL cg_tx[%0d] got %b want %b", i, tr_tx[i], e); end
      tests++; if (tr_pop[i] !== (i == 0)) begin fails++; $display("FAIL cg_pop[%0d] got %b want %b", i, tr_pop[i], i == 0); end
      tests++; if (tr_done[i] !== (i == 43)) begin fails++; $display("FAIL cg_done[%0d] got %b want %b", i, tr_done[i], i == 43); end
      tests++; if (tr_busy[i] !== (i >= 1 && i <= 43)) begin fails++; $display("FAIL cg_busy[%0d] got %b want %b", i, tr_busy[i], i >= 1 && i <= 43); end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit_period = 16'd4;
    push(8'h5A);
    push(8'h3C);
    capture(15, -1, -1, -1, 16'd0);
    tests++; if (tr_pop[0] !== 1'b1) begin fails++; $display("FAIL rmid_first_pop got %b want 1", tr_pop[0]); end
    tests++; if (tr_tx[14] !== 1'b0) begin fails++; $display("FAIL rmid_bit2_before got %b want 0", tr_tx[14]); end
    rst_n = 1'b0;
    #1;
    tests++; if (tx !== 1'b1) begin fails++; $display("FAIL rmid_tx got %b want 1", tx); end
    for (int i = 0; i < 2; i++) begin
      #1;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_busy[%0d] got %b want 0", i, busy); end
      tests++; if (ifc.pop !== 1'b0) begin fails++; $display("FAIL rmid_pop[%0d] got %b want 0", i, ifc.pop); end
      step();
    end
    rst_n = 1'b1;
    capture(42, -1, -1, -1, 16'd0);
    tests++; if (tr_pop[0] !== 1'b1) begin fails++; $display("FAIL rmid_release_pop got %b want 1", tr_pop[0]); end
    for (int i = 1; i < 42; i++) begin
      tests++; if (tr_tx[i] !== exp_tx(i, 8'h3C, 4)) begin fails++; $display("FAIL rmid_tx[%0d] got %b want %b", i, tr_tx[i], exp_tx(i, 8'h3C, 4)); end
      tests++; if (tr_done[i] !== (i == 40)) begin fails++; $display("FAIL rmid_done[%0d] got %b want %b", i, tr_done[i], i == 40); end
    end
    tests++; if (fq.size() !== 0) begin fails++; $display("FAIL rmid_fifo_level got %0d want 0", fq.size()); end
  endtask

  task automatic test_period_change();
    bit_period = 16'd3;
    push(8'h81);
    capture(32, -1, -1, 10, 16'd7);
    for (int i = 0; i < 32; i++) begin
      tests++; if (tr_tx[i] !== exp_tx(i, 8'h81, 3)) begin fails++; $display("FAIL pchg_tx[%0d] got %b want %b", i, tr_tx[i], exp_tx(i, 8'h81, 3)); end
      tests++; if (tr_done[i] !== (i == 30)) begin fails++; $display("FAIL pchg_done[%0d] got %b want %b", i, tr_done[i], i == 30); end
      tests++; if (tr_busy[i] !== (i >= 1 && i <= 30)) begin fails++; $display("FAIL pchg_busy[%0d] got %b want %b", i, tr_busy[i], i >= 1 && i <= 30); end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    cg         = 1'b1;
    bit_period = 16'd4;
    refresh();
    @(negedge clk);
    test_reset();
    test_idle_empty();
    test_single_frame();
    test_back_to_back();
    test_zero_period();
    test_clock_gate();
    test_reset_mid_frame();
    test_period_change();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Drain stage that sits directly downstream of a `fifo` instance: it pops one WIDTH-bit entry at a time and serialises it as an asynchronous UART frame. A frame is one start bit, WIDTH data bits LSB first, and one stop bit. Frames are sent back-to-back, without idle gaps, while the fifo is non-empty. Typical use is a byte fifo feeding a host debug/serial link.

## Interface
Parameters:
- WIDTH, 8, data bits per frame; must be ≥1 and match the upstream fifo WIDTH.
- PERIOD_W, 16, width of the bit-period input.

Ports:
- i_clk  input  1  sole clock.
- i_rst  input  1  reset; one clock, reset is asynchronous and active-low.
- i_cg  input  1  clock-gate enable; 0 freezes all state.
- i_empty  input  1  from fifo o_empty.
- i_data  input  WIDTH  from fifo o_data; fifo head, valid whenever i_empty=0.
- o_pop  output  1  to fifo i_pop.
- i_bitPeriod  input  PERIOD_W  clock cycles per UART bit; 0 is treated as 1.
- o_tx  output  1  serial line, idle high.
- o_busy  output  1  frame in progress (state ≠ IDLE).
- o_frameDone  output  1  one-cycle pulse on the last cycle of a stop bit.

## Operation
- FSM states: IDLE, START, DATA, STOP. Encodings are localparams.
- P = max(i_bitPeriod, 1). P is latched into a period register on each pop and stays constant for that frame; changes to i_bitPeriod mid-frame are ignored.
- o_pop = i_rst & i_cg & ~i_empty & (IDLE | (STOP & lastCycleOfBit)). It is combinational (Mealy) so a frame can follow the previous one with no gap.
- On a pop cycle:
  - i_data is captured into the shift register.
  - The period and bit counters are cleared.
  - The next state is START.
- START: o_tx=0 for P cycles, then DATA.
- DATA: o_tx=shift[0]. After every P cycles the register shifts right and the bit counter increments. After WIDTH bits the next state is STOP.
- STOP: o_tx=1 for P cycles. On the last cycle o_frameDone=1. From there the block either pops again and goes to START, or goes to IDLE.
- o_tx, o_busy and o_frameDone are registered or decoded from registered state only; no combinational path from i_empty/i_data.
- Counters:
  - Period counter is PERIOD_W bits and counts 0..P-1.
  - Bit counter is $clog2(WIDTH) bits, minimum 1. It wraps only via the state change, never via arithmetic overflow.
- i_cg=0:
  - Counters, shift register and state hold.
  - o_tx holds its value, so the current bit is stretched.
  - o_pop=0 and o_frameDone=0.
- No flush input. Aborting a frame requires reset.

## Timing
- Reset values: state IDLE, o_tx=1, o_busy=0, o_frameDone=0, o_pop=0. o_pop is held low while i_rst=0 even if the fifo is non-empty.
- Reset asserted mid-frame: o_tx returns to 1 asynchronously and the popped entry is discarded.
- Pop in cycle t:
  - START occupies cycles t+1..t+P.
  - Data bit k occupies cycles t+(k+1)P+1..t+(k+2)P.
  - STOP occupies cycles t+(WIDTH+1)P+1..t+(WIDTH+2)P.
  - o_frameDone is high in cycle t+(WIDTH+2)P.
- Back-to-back frames: the next pop happens in the o_frameDone cycle, and the next start bit begins one cycle later. Throughput is exactly one frame per (WIDTH+2)·P cycles.
- Fifo becomes non-empty while the block is in IDLE: pop in the same cycle, o_tx falls one cycle later.
- Simultaneous fifo push and this pop: handled entirely by the fifo; this block observes only i_empty.
- o_pop is never high on two consecutive cycles (minimum frame is WIDTH+2 ≥ 3 cycles).

## Structure
- State encodings, the idle line level, and the frame-length function (WIDTH+2)·P go in the shared uart include/package. The future uart_rx reuses them.
- Single flat module. No sub-module is warranted: counter plus shift register plus a 4-state FSM.
- Target size is about 150 RTL lines.

## Test plan
- WIDTH=8, P=4, single push of 0xA5 while idle:
  - Pop at t.
  - o_tx=0 for t+1..t+4.
  - Then data bits 1,0,1,0,0,1,0,1 for 4 cycles each.
  - Then 1 for t+37..t+40.
  - o_frameDone at t+40; returns to IDLE with o_busy=0 at t+41.
- P=2, fifo preloaded with 0x00, 0xFF:
  - Pops at t and t+20.
  - Second start bit at t+21.
  - o_tx never high between the frames except the stop bit.
- i_bitPeriod=0: each bit lasts 1 cycle, frame is 10 cycles, o_frameDone at t+10.
- P=4, i_cg=0 for 3 cycles during data bit 2: bit 2 lasts 7 cycles, o_frameDone at t+43, no pop while i_cg=0.
- Reset low at t+15 of a frame:
  - o_tx=1 immediately; o_busy=0 and o_pop=0 during reset.
  - After release with the fifo non-empty, a new pop occurs on the first cycle.
- Fifo empty for 100 cycles: o_pop=0, o_tx=1, o_busy=0 throughout. A change to i_bitPeriod mid-frame does not alter the current frame's length.
